// File: rtl/debounce_pkg.sv
// Shared state encoding and default filter length for the tick-driven debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    localparam int STABLE_DEFAULT = 3;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for bringing an asynchronous board input into the clk domain.
module sync_2ff
    import debounce_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/tick_debouncer.sv
// Switch debouncer paced by an external tick strobe; emits a clean level and a rising-edge pulse.
// Define DEBOUNCE_SYNC_EN to pass sw through a two-flop synchroniser first (adds 2 clk latency).
module tick_debouncer
    import debounce_pkg::*;
#(
    parameter int Stable = STABLE_DEFAULT,
    localparam int CntWidth = $clog2(Stable + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    logic                w_s;
    state_t              r_state;
    state_t              w_nextState;
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_nextCnt;
    logic                r_dbTick;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (w_s)
    );
`else
    assign w_s = sw;
`endif

    // A bounce back to the stable value always wins over a coincident tick.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            ZERO: begin
                if (w_s) begin
                    w_nextState = WAIT1;
                    w_nextCnt   = CntWidth'(Stable);
                end
            end
            WAIT1: begin
                if (!w_s) begin
                    w_nextState = ZERO;
                end else if (tick) begin
                    if (r_cnt == CntWidth'(1)) begin
                        w_nextState = ONE;
                    end else begin
                        w_nextCnt = r_cnt - CntWidth'(1);
                    end
                end
            end
            ONE: begin
                if (!w_s) begin
                    w_nextState = WAIT0;
                    w_nextCnt   = CntWidth'(Stable);
                end
            end
            WAIT0: begin
                if (w_s) begin
                    w_nextState = ONE;
                end else if (tick) begin
                    if (r_cnt == CntWidth'(1)) begin
                        w_nextState = ZERO;
                    end else begin
                        w_nextCnt = r_cnt - CntWidth'(1);
                    end
                end
            end
            default: begin
                w_nextState = ZERO;
            end
        endcase
    end

    // The pulse is registered so it lines up with the first cycle of the ONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ZERO;
            r_cnt    <= '0;
            r_dbTick <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_dbTick <= (r_state == WAIT1) && (w_nextState == ONE);
        end
    end

    assign db_level = (r_state == ONE) || (r_state == WAIT0);
    assign db_tick  = r_dbTick;

endmodule

// File: tb/tb_tick_debouncer.sv
// Scoreboard bench for tick_debouncer: stimulus pushes model predictions, a monitor pops and compares.
// The reference model follows DEBOUNCE_SYNC_EN so the same bench serves both builds.
module tb_tick_debouncer;

    localparam int STABLE = 3;

    logic clk  = 1'b1;
    logic rst  = 1'b1;
    logic tick = 1'b0;
    logic sw   = 1'b0;
    logic db_level;
    logic db_tick;

    typedef struct {
        bit level;
        bit pulse;
        int cycle;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   passes   = 0;
    int   cycle    = 0;
    int   phase    = 0;
    int   tickMode = 0;

    // Model state: the clean level and an open mismatch run with its tick tally.
    bit       mLevel  = 1'b0;
    bit       mActive = 1'b0;
    int       mTicks  = 0;
    bit [1:0] mPipe   = 2'b00;

    tick_debouncer #(.Stable(STABLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    always #5 clk = ~clk;

    // Level flips once the input has disagreed with it for STABLE ticks, not counting the first cycle.
    task automatic modelStep(input bit r, input bit t, input bit w, output bit eLevel, output bit ePulse);
        bit s;
        ePulse = 1'b0;
        if (r) begin
            mLevel  = 1'b0;
            mActive = 1'b0;
            mTicks  = 0;
            mPipe   = 2'b00;
        end else begin
`ifdef DEBOUNCE_SYNC_EN
            s     = mPipe[1];
            mPipe = {mPipe[0], w};
`else
            s = w;
`endif
            if (s == mLevel) begin
                mActive = 1'b0;
            end else if (!mActive) begin
                mActive = 1'b1;
                mTicks  = 0;
            end else if (t) begin
                mTicks++;
                if (mTicks == STABLE) begin
                    mLevel  = ~mLevel;
                    mActive = 1'b0;
                    ePulse  = mLevel;
                end
            end
        end
        eLevel = mLevel;
    endtask

    task automatic applyStimulus(input bit r, input bit w);
        exp_t e;
        bit   t;
        @(negedge clk);
        case (tickMode)
            0:       t = (phase == 3);
            1:       t = ($urandom_range(0, 2) == 0);
            default: t = 1'b1;
        endcase
        phase = (phase + 1) % 4;
        rst   = r;
        sw    = w;
        tick  = t;
        modelStep(r, t, w, e.level, e.pulse);
        e.cycle = cycle;
        cycle++;
        expQ.push_back(e);
    endtask

    task automatic holdFor(input int n, input bit w);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, w);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (db_level === e.level) passes++;
        else $display("[TB] FAIL db_level cycle %0d: got %b expected %b", e.cycle, db_level, e.level);
        checks++;
        if (db_tick === e.pulse) passes++;
        else $display("[TB] FAIL db_tick cycle %0d: got %b expected %b", e.cycle, db_tick, e.pulse);
    endtask

    // Monitor: every clk edge the DUT presents a new output pair.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_empty at time %0t: got no prediction expected one", $time);
        end else begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        // Reset with sw high and tick held, then one cycle after release.
        tickMode = 2;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
        tickMode = 0;
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0);

        // Clean press, held for 50 ticks.
        holdFor(10, 1'b0);
        holdFor(200, 1'b1);

        // Release, then bounce every 3 clk before settling high.
        holdFor(30, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, ((i / 3) % 2) == 0);
        holdFor(30, 1'b1);

        // Release with a one-clk glitch back high.
        holdFor(4, 1'b0);
        holdFor(1, 1'b1);
        holdFor(30, 1'b0);

        // Reset in the middle of WAIT1, then a full filter window again.
        holdFor(8, 1'b1);
        applyStimulus(1'b1, 1'b1);
        holdFor(30, 1'b1);
        holdFor(30, 1'b0);

        // Randomised segments with varying tick cadence and occasional reset.
        for (int seg = 0; seg < 120; seg++) begin
            bit lvl;
            int len;
            tickMode = $urandom_range(0, 2);
            lvl      = $urandom_range(0, 1);
            len      = $urandom_range(1, 18);
            if ($urandom_range(0, 19) == 0) applyStimulus(1'b1, lvl);
            holdFor(len, lvl);
        end

        @(posedge clk);
        #2;
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
